// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4:1 mux scan controller.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mux_scan_timer.sv
// Settle counter: loadable down-counter with a zero flag, synchronous active-high reset.
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks sel 0..3 over a downstream 4:1 mux, capturing one bit per channel into sample.
// Optional parity output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              y_in,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] sample
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              parity
`endif
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    state_e            r_state, w_state_next;
    logic [SEL_W-1:0]  r_sel, w_sel_next;
    logic [NUM_CH-1:0] r_shadow, w_shadow_next;
    logic [NUM_CH-1:0] r_sample, w_sample_next;
    logic              r_busy, r_done;
    logic              w_load, w_dec, w_zero;

    mux_scan_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_shadow <= '0;
            r_sample <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sel    <= w_sel_next;
            r_shadow <= w_shadow_next;
            r_sample <= w_sample_next;
            r_busy   <= (w_state_next == SETTLE);
            r_done   <= (w_state_next == DONE);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_sel_next    = r_sel;
        w_shadow_next = r_shadow;
        w_sample_next = r_sample;
        w_load        = 1'b0;
        w_dec         = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_sel_next = '0;
                if (start) begin
                    w_state_next = SETTLE;
                    w_load       = 1'b1;
                end
            end
            SETTLE: begin
                if (!w_zero) begin
                    w_dec = 1'b1;
                end else begin
                    w_shadow_next[r_sel] = y_in;
                    if (r_sel == LAST_CH) begin
                        // Last bit lands in sample on the same edge it is captured.
                        w_state_next  = DONE;
                        w_sample_next = w_shadow_next;
                        w_sel_next    = '0;
                    end else begin
                        w_sel_next = r_sel + 1'b1;
                        w_load     = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_sel_next   = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_sel_next   = '0;
            end
        endcase
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_sample_next;
        end
    end

    assign parity = r_parity;
`endif

    assign sel    = r_sel;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sample = r_sample;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 1, cycles the select is held per channel before capture (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  scan request, sampled only in IDLE.
REQ-005 SHALL have port: y_in  input  1  selected bit returned by the downstream 4:1 one-bit mux.
REQ-006 SHALL have port: sel  output  2  channel select driven to the mux.
REQ-007 SHALL have port: busy  output  1  high while a scan is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse, scan result valid.
REQ-009 SHALL have port: sample  output  4  captured channel bits, bit i = channel i.

Function
REQ-010 SHALL implement FSM states IDLE, SETTLE, DONE; all outputs registered.
REQ-011 SHALL, in IDLE with start=1, move to SETTLE with sel=0 and settle counter=SETTLE_CYCLES-1 on the same edge.
REQ-012 SHALL, in SETTLE with counter>0, decrement the counter and hold sel.
REQ-013 SHALL, in SETTLE with counter=0, write y_in into shadow bit [sel]; if sel<3, increment sel and reload counter; if sel=3, go to DONE.
REQ-014 SHALL, on the edge entering DONE, copy the shadow into sample; sample holds until the next entry into DONE.
REQ-015 SHALL assert done only in DONE (exactly one cycle); DONE always returns to IDLE.
REQ-016 SHALL assert busy only in SETTLE.
REQ-017 SHALL hold each sel value for exactly SETTLE_CYCLES cycles; done rises 4*SETTLE_CYCLES+1 cycles after the start-sampling edge.
REQ-018 SHALL ignore start in SETTLE and DONE (no queuing, no restart).
REQ-019 SHALL drive sel=0 in IDLE and DONE.
REQ-020 SHALL wrap sel only via the DONE path, never 3->0 inside a scan.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, go to IDLE with sel=0, busy=0, done=0, sample=0, shadow=0, counter=0.
REQ-022 SHALL abort a scan on reset mid-operation with no done pulse and sample=0.
REQ-023 SHALL give reset priority over start on the same edge.

Configuration
REQ-024 SHALL, with MUX_SCAN_PARITY_EN defined, add output port parity (1 bit): XOR of the four sample bits, updated on the same edge as sample, reset to 0.
REQ-025 SHALL, without MUX_SCAN_PARITY_EN, omit the parity port and its logic; all other behaviour is identical.

Structure
REQ-026 SHALL place in shared package mux_scan_pkg: state enum (IDLE, SETTLE, DONE), NUM_CH=4, SEL_W=2, CNT_W=4.
REQ-027 SHALL implement the settle counter as sub-module mux_scan_timer (load, decrement, zero flag).

Verification
REQ-028 SHALL cover: SETTLE_CYCLES=1, mux data 4'b1010, start at cycle 0 -> sel 0,1,2,3 in cycles 1-4, done at cycle 5, sample=4'b1010, parity=0.
REQ-029 SHALL cover: SETTLE_CYCLES=3, data 4'b0111 -> each sel held 3 cycles, done at cycle 13, sample=4'b0111, parity=1.
REQ-030 SHALL cover: start re-pulsed at cycles 2 and 5 (SETTLE=1) and in the DONE cycle -> single scan, one done pulse only.
REQ-031 SHALL cover: reset at cycle 3 mid-scan -> next cycle sel=0, busy=0, sample=0, no done for that scan.
REQ-032 SHALL cover: back-to-back scans, data 4'b1010 then 4'b0001 -> sample stays 4'b1010 through scan 2, becomes 4'b0001 at second done.
REQ-033 SHALL cover: simultaneous reset and start in IDLE -> stays IDLE, busy=0.
